// File: rtl/dpll_core.sv
// First-order all-digital PLL (74HC297 style): reference synchronizer, XOR phase
// detector, K up/down counter, increment/decrement pulse circuit and divide-by-N output.
module dpll_core #(
    parameter int K_WIDTH = 4,
    parameter int N_DIV   = 12
) (
    input  logic oscInput,
    input  logic reset,
    input  logic baseClockInput,
    output logic dpllOutput,
    output logic xorOutput
);
    localparam int                 DIV_W    = (N_DIV > 1) ? $clog2(N_DIV) : 1;
    localparam logic [K_WIDTH-1:0] K_MID    = {1'b1, {(K_WIDTH-1){1'b0}}};
    localparam logic [K_WIDTH-1:0] K_MAX    = '1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(N_DIV - 1);

    logic               sync_meta;
    logic               ref_sync;
    logic               pd;
    logic [K_WIDTH-1:0] k_cnt;
    logic               carry;
    logic               borrow;
    logic               id_phase;
    logic               insert_pending;
    logic               delete_pending;
    logic               insert_next;
    logic               delete_next;
    logic               id_en;
    logic [DIV_W-1:0]   div_cnt;

    always_ff @(posedge oscInput) begin
        if (reset) begin
            sync_meta <= 1'b0;
            ref_sync  <= 1'b0;
        end else begin
            sync_meta <= baseClockInput;
            ref_sync  <= sync_meta;
        end
    end

    assign pd        = ref_sync ^ dpllOutput;
    assign xorOutput = pd;

    // carry/borrow flag the edge on which the K counter wraps
    assign carry  = pd & (k_cnt == K_MAX);
    assign borrow = ~pd & (k_cnt == '0);

    always_ff @(posedge oscInput) begin
        if (reset) begin
            k_cnt <= K_MID;
        end else if (pd) begin
            k_cnt <= k_cnt + 1'b1;
        end else begin
            k_cnt <= k_cnt - 1'b1;
        end
    end

    // A pending correction is consumed first; a new carry/borrow then cancels the
    // opposite request or arms its own, so at most one correction is ever waiting.
    always_comb begin
        id_en       = id_phase;
        insert_next = insert_pending;
        delete_next = delete_pending;
        if (insert_pending && !id_phase) begin
            id_en       = 1'b1;
            insert_next = 1'b0;
        end else if (delete_pending && id_phase) begin
            id_en       = 1'b0;
            delete_next = 1'b0;
        end
        if (carry) begin
            if (delete_next) begin
                delete_next = 1'b0;
            end else begin
                insert_next = 1'b1;
            end
        end else if (borrow) begin
            if (insert_next) begin
                insert_next = 1'b0;
            end else begin
                delete_next = 1'b1;
            end
        end
    end

    always_ff @(posedge oscInput) begin
        if (reset) begin
            id_phase       <= 1'b0;
            insert_pending <= 1'b0;
            delete_pending <= 1'b0;
        end else begin
            id_phase       <= ~id_phase;
            insert_pending <= insert_next;
            delete_pending <= delete_next;
        end
    end

    always_ff @(posedge oscInput) begin
        if (reset) begin
            div_cnt    <= '0;
            dpllOutput <= 1'b0;
        end else if (id_en) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt    <= '0;
                dpllOutput <= ~dpllOutput;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dpll_core.sv
// Self-checking bench for dpll_core: integer-level behavioural model compared every
// cycle, plus free-run, insert, lock, fast-reference and mid-lock reset scenarios.
module tb_dpll_core;
    localparam int K_WIDTH = 4;
    localparam int N_DIV   = 12;
    localparam int K_MAX   = (1 << K_WIDTH) - 1;
    localparam int K_MID   = 1 << (K_WIDTH - 1);

    logic oscInput       = 1'b0;
    logic reset          = 1'b1;
    logic baseClockInput = 1'b0;
    logic dpllOutput;
    logic xorOutput;

    logic reset8 = 1'b1;
    logic base8  = 1'b0;
    logic dpll8;
    logic xor8;

    int checkCount = 0;
    int errorCount = 0;

    // behavioural model state: plain integers, output derived from total enable count
    int mSync1, mRef, mOut, mK, mPend, mCycles, mEnables;
    int carrySeen;
    int refPhase;
    logic outHist[$];
    logic xorHist[$];

    int idx, sum, minP, maxP, got, lastRst, prevT, minHalf;
    int wMin, wMax, wTot, cnt, period, high;
    logic baseV;

    bit freeDone = 1'b0;
    int freePrev, freeToggles, kMin, kMax;

    dpll_core #(.K_WIDTH(K_WIDTH), .N_DIV(N_DIV)) dut (
        .oscInput       (oscInput),
        .reset          (reset),
        .baseClockInput (baseClockInput),
        .dpllOutput     (dpllOutput),
        .xorOutput      (xorOutput)
    );

    dpll_core #(.K_WIDTH(8), .N_DIV(N_DIV)) dut8 (
        .oscInput       (oscInput),
        .reset          (reset8),
        .baseClockInput (base8),
        .dpllOutput     (dpll8),
        .xorOutput      (xor8)
    );

    always #1 oscInput = ~oscInput;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input logic rstV, input logic bV);
        int  pd;
        bit  nominal;
        bit  en;
        bit  carryM;
        bit  borrowM;
        if (rstV) begin
            mSync1 = 0; mRef = 0; mOut = 0; mK = K_MID;
            mPend = 0; mCycles = 0; mEnables = 0;
            return;
        end
        pd      = mRef ^ mOut;
        nominal = (mCycles % 2) == 1;
        en      = nominal;
        if (mPend == 1 && !nominal) begin
            en    = 1'b1;
            mPend = 0;
        end else if (mPend == -1 && nominal) begin
            en    = 1'b0;
            mPend = 0;
        end
        carryM  = (pd == 1) && (mK == K_MAX);
        borrowM = (pd == 0) && (mK == 0);
        mK = (pd == 1) ? (mK + 1) % (K_MAX + 1) : (mK + K_MAX) % (K_MAX + 1);
        if (carryM)  mPend = (mPend == -1) ? 0 : 1;
        if (borrowM) mPend = (mPend == 1) ? 0 : -1;
        mRef   = mSync1;
        mSync1 = int'(bV);
        if (en) begin
            mEnables++;
            mOut = (mEnables / N_DIV) % 2;
        end
        mCycles++;
    endtask

    // drive one cycle, advance the model, then compare away from the active edge
    task automatic applyStimulus(input logic rstV, input logic bV);
        reset          = rstV;
        baseClockInput = bV;
        @(posedge oscInput);
        modelStep(rstV, bV);
        @(negedge oscInput);
        if (dut.carry) carrySeen++;
        outHist.push_back(dpllOutput);
        xorHist.push_back(xorOutput);
        checkOutput("dpll", int'(dpllOutput), mOut);
        checkOutput("xor", int'(xorOutput), mRef ^ mOut);
        checkOutput("kcnt", int'(dut.k_cnt), mK);
    endtask

    task automatic runRef(input int per, input int hi, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            applyStimulus(1'b0, (refPhase % per) < hi);
            refPhase++;
        end
    endtask

    task automatic measure(input int startIdx, input int nPeriods,
                           output int s, output int mn, output int mx, output int n);
        int last;
        last = -1; s = 0; mn = 1000000; mx = 0; n = 0;
        for (int i = startIdx + 1; i < outHist.size(); i++) begin
            if (outHist[i] && !outHist[i-1]) begin
                if (last >= 0 && n < nPeriods) begin
                    s += i - last;
                    if (i - last < mn) mn = i - last;
                    if (i - last > mx) mx = i - last;
                    n++;
                end
                last = i;
            end
        end
    endtask

    // free-running K_WIDTH=8 instance with a grounded reference
    initial begin
        kMin = 1000; kMax = 0; freeToggles = 0;
        repeat (10) @(negedge oscInput);
        checkOutput("free_rst_k", int'(dut8.k_cnt), 128);
        checkOutput("free_rst_out", int'(dpll8), 0);
        reset8   = 1'b0;
        freePrev = 0;
        for (int c = 1; c <= 24 * 7; c++) begin
            @(negedge oscInput);
            if (int'(dut8.k_cnt) < kMin) kMin = int'(dut8.k_cnt);
            if (int'(dut8.k_cnt) > kMax) kMax = int'(dut8.k_cnt);
            if (int'(dpll8) != freePrev) begin
                freeToggles++;
                if (freeToggles <= 7) checkOutput("free_toggle_cycle", c, 24 * freeToggles);
                freePrev = int'(dpll8);
            end
        end
        checkOutput("free_toggle_count", freeToggles, 7);
        checkOutput("free_kmin", kMin, 104);
        checkOutput("free_kmax", kMax, 128);
        freeDone = 1'b1;
    end

    initial begin
        carrySeen = 0;

        // reset held with a toggling reference
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)));
            checkOutput("rst_dpll", int'(dpllOutput), 0);
            checkOutput("rst_xor", int'(xorOutput), 0);
            checkOutput("rst_k", int'(dut.k_cnt), K_MID);
        end

        // constant-high reference forces carries and shortened half-periods
        lastRst   = outHist.size() - 1;
        carrySeen = 0;
        for (int i = 0; i < 400; i++) applyStimulus(1'b0, 1'b1);
        minHalf = 1000;
        prevT   = lastRst;
        for (int i = lastRst + 1; i < outHist.size(); i++) begin
            if (outHist[i] != outHist[i-1]) begin
                if (i - prevT < minHalf) minHalf = i - prevT;
                prevT = i;
            end
        end
        checkOutput("ins_carry_seen", int'(carrySeen > 0), 1);
        checkOutput("ins_short_half", int'(minHalf < 24), 1);

        // lock to a 50-cycle reference
        applyStimulus(1'b1, 1'b0);
        refPhase = $urandom_range(0, 49);
        runRef(50, 25, 3000);
        idx = outHist.size();
        runRef(50, 25, 700);
        measure(idx, 10, sum, minP, maxP, got);
        checkOutput("lock50_periods", got, 10);
        checkOutput("lock50_avg", int'(sum >= 496 && sum <= 504), 1);
        checkOutput("lock50_range", int'(minP >= 46 && maxP <= 54), 1);
        wMin = 1000; wMax = 0; wTot = 0;
        for (int w = 0; w < 10; w++) begin
            cnt = 0;
            for (int j = 0; j < 50; j++) cnt += int'(xorHist[idx + 50 * w + j]);
            if (cnt < wMin) wMin = cnt;
            if (cnt > wMax) wMax = cnt;
            wTot += cnt;
        end
        checkOutput("lock50_xor_stable", int'(wMax - wMin <= 8), 1);
        checkOutput("lock50_xor_duty", int'(wTot >= 130 && wTot <= 210), 1);

        // single-cycle reset while locked, then re-lock
        applyStimulus(1'b1, (refPhase % 50) < 25);
        refPhase++;
        checkOutput("midrst_dpll", int'(dpllOutput), 0);
        checkOutput("midrst_xor", int'(xorOutput), 0);
        checkOutput("midrst_k", int'(dut.k_cnt), K_MID);
        runRef(50, 25, 3000);
        idx = outHist.size();
        runRef(50, 25, 700);
        measure(idx, 10, sum, minP, maxP, got);
        checkOutput("relock_periods", got, 10);
        checkOutput("relock_avg", int'(sum >= 496 && sum <= 504), 1);

        // faster 46-cycle reference locks with xor duty above half
        applyStimulus(1'b1, 1'b0);
        refPhase = $urandom_range(0, 45);
        runRef(46, 23, 3000);
        idx = outHist.size();
        runRef(46, 23, 600);
        measure(idx, 10, sum, minP, maxP, got);
        checkOutput("fast46_periods", got, 10);
        checkOutput("fast46_avg", int'(sum >= 456 && sum <= 464), 1);
        cnt = 0;
        for (int j = 0; j < 460; j++) cnt += int'(xorHist[idx + j]);
        checkOutput("fast46_xor_duty", int'(cnt > 230), 1);

        // random reference periods, duty and sporadic resets against the model
        for (int seg = 0; seg < 4; seg++) begin
            period   = $urandom_range(44, 54);
            high     = $urandom_range(period / 3, (2 * period) / 3);
            refPhase = $urandom_range(0, period - 1);
            for (int c = 0; c < 1500; c++) begin
                baseV = (refPhase % period) < high;
                refPhase++;
                applyStimulus($urandom_range(0, 599) == 0, baseV);
            end
        end

        wait (freeDone);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
